// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB/bimodal branch predictor.
package branch_predictor_pkg;

  localparam int          BP_ENTRIES = 64;
  localparam int          BP_IDX_W   = 6;
  localparam int          BP_TAG_W   = 24;
  localparam logic [1:0]  CNT_RESET  = 2'b01;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic                jmp;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// 64-entry BTB + 2-bit counter predictor; zero-latency lookup, update visible the edge after upd_en, no backpressure.
// Optional GSHARE_EN: counters indexed by pc[7:2] XOR a 6-bit global taken history.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        predict_f,
  output logic [31:0] target_f,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_predict,
  output logic        mispred_e,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  btb_entry_t btb [BP_ENTRIES];
  logic [1:0] pht [BP_ENTRIES];

  logic [BP_IDX_W-1:0] f_idx, u_idx, f_cidx, u_cidx;
  btb_entry_t          f_ent, wr_ent;
  logic                f_hit;
  logic                unused_pc_lsb;

  assign f_idx = pc_f[7:2];
  assign u_idx = upd_pc[7:2];
  assign unused_pc_lsb = ^{pc_f[1:0], upd_pc[1:0]};

`ifdef GSHARE_EN
  logic [BP_IDX_W-1:0] ghr;

  assign f_cidx = f_idx ^ ghr;
  assign u_cidx = u_idx ^ ghr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_en && upd_is_br) begin
      ghr <= {ghr[BP_IDX_W-2:0], upd_taken};
    end
  end
`else
  assign f_cidx = f_idx;
  assign u_cidx = u_idx;
`endif

  // Lookup reads the array as it stands, so a same-cycle update is not visible yet.
  assign f_ent     = btb[f_idx];
  assign f_hit     = f_ent.valid && (f_ent.tag == pc_f[31:8]);
  assign predict_f = f_hit && (f_ent.jmp || pht[f_cidx][1]);
  assign target_f  = f_hit ? f_ent.target : pc_f + 32'd4;

  assign mispred_e = upd_en && (upd_predict != upd_taken);

  assign wr_ent = '{valid:  1'b1,
                    tag:    upd_pc[31:8],
                    target: upd_target,
                    jmp:    !upd_is_br};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        pht[i]       <= CNT_RESET;
      end
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (upd_en) begin
      if (upd_is_br) begin
        pht[u_cidx] <= upd_taken ? sat_inc(pht[u_cidx]) : sat_dec(pht[u_cidx]);
        if (br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      end
      // Not-taken branches never allocate; jumps and taken branches always (re)write.
      if (!upd_is_br || upd_taken) btb[u_idx] <= wr_ent;
      if (mispred_e && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
